// File: rtl/add3bit_pkg.sv
// Shared definitions for the digit-serial add3bit controller.
package add3bit_pkg;

    // Width of one add3bit digit slice.
    localparam int DIGIT_W = 3;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/add3bit.sv
// Three-bit adder slice with carry in/out: {Cout, Sum} = A + B + Cin.
module add3bit
    import add3bit_pkg::*;
(
    input  logic [DIGIT_W-1:0] A,
    input  logic [DIGIT_W-1:0] B,
    input  logic               Cin,
    output logic [DIGIT_W-1:0] Sum,
    output logic               Cout
);

    // Pure combinational digit add; one extra bit captures the carry.
    assign {Cout, Sum} = {1'b0, A} + {1'b0, B} + {{DIGIT_W{1'b0}}, Cin};

endmodule

// File: rtl/add3bit_serial_ctrl.sv
// Digit-serial WIDTH-bit adder: reuses one add3bit slice, LSD first,
// with a registered carry chaining one digit to the next.
//
// Handshake: start is sampled on every rising edge but only accepted in
// IDLE or DONE; the accepting edge captures a, b and cin. done is a
// one-cycle pulse exactly NDIG edges later, and sum/cout are valid from
// that pulse until the next done. start during RUN is dropped, not queued.
module add3bit_serial_ctrl
    import add3bit_pkg::*;
#(
    parameter int WIDTH = 12
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output state_t           state_dbg
);

    localparam int NDIG  = WIDTH / DIGIT_W;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);

    // Reject widths that do not split into whole digits.
    if ((WIDTH % DIGIT_W) != 0 || WIDTH < DIGIT_W) begin : g_bad_width
        $error("add3bit_serial_ctrl: WIDTH must be a multiple of 3 and >= 3");
    end

    state_t             state;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   res_sh;
    logic [WIDTH-1:0]   res_next;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic [DIGIT_W-1:0] d_sum;
    logic               d_cout;
    logic               accept;

    // The one shared digit slice.
    add3bit u_add3bit (
        .A    (a_sh[DIGIT_W-1:0]),
        .B    (b_sh[DIGIT_W-1:0]),
        .Cin  (carry),
        .Sum  (d_sum),
        .Cout (d_cout)
    );

    // Next result word: shift right one digit, new digit enters at the top.
    always_comb begin
        res_next = res_sh >> DIGIT_W;
        res_next[WIDTH-1 -: DIGIT_W] = d_sum;
    end

    assign accept    = start && (state == IDLE || state == DONE);
    assign state_dbg = state;

    // Controller FSM, operand/result shifting and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                a_sh   <= a;
                b_sh   <= b;
                carry  <= cin;
                cnt    <= '0;
                res_sh <= '0;
                busy   <= 1'b1;
                state  <= RUN;
            end else begin
                case (state)
                    RUN: begin
                        a_sh   <= a_sh >> DIGIT_W;
                        b_sh   <= b_sh >> DIGIT_W;
                        res_sh <= res_next;
                        carry  <= d_cout;
                        if (cnt == LAST_CNT) begin
                            sum   <= res_next;
                            cout  <= d_cout;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/add3bit_serial_ctrl.md
Name: add3bit_serial_ctrl

Overview:
Digit-serial multi-word adder controller. It reuses one add3bit slice to add two WIDTH-bit operands, 3 bits per clock, least significant digit first. A registered carry chains each digit to the next. It sits between a requester using a start/done handshake and the existing add3bit datapath, and it owns all sequencing, operand shifting and result assembly.

Parameters:
WIDTH, 12, operand and sum width in bits; must be a multiple of 3 and at least 3 (elaboration-time check, $error otherwise)
NDIG, WIDTH/3, derived localparam: number of digit cycles per add

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled on the rising edge; accepted only in IDLE or DONE
a  input  WIDTH  operand A, captured on the accepting edge
b  input  WIDTH  operand B, captured on the accepting edge
cin  input  1  carry-in, captured on the accepting edge
busy  output  1  high while in RUN
done  output  1  one-cycle pulse, high only in DONE
sum  output  WIDTH  result; valid from done onward; held until the next accepted start
cout  output  1  final carry-out; same validity as sum

Behaviour:
- Reset (async, active-high): state=IDLE; busy=0, done=0, sum=0, cout=0; shift registers, carry register and digit counter cleared.
- Reset asserted mid-RUN: the operation is abandoned immediately; no done pulse; all outputs take their reset values.
- States:
  - IDLE: start -> RUN.
  - RUN: after digit counter reaches NDIG-1 -> DONE.
  - DONE: start -> RUN (back-to-back accepted); else -> IDLE.
- Accepting edge:
  - a_sh<=a, b_sh<=b, carry<=cin, cnt<=0.
  - Result shift register cleared.
  - sum/cout keep their old values until the new done.
- Each RUN edge (one digit per edge):
  - add3bit inputs: A=a_sh[2:0], B=b_sh[2:0], Cin=carry.
  - a_sh, b_sh shift right by 3.
  - Result register shifts right by 3, with the add3bit Sum entering at [WIDTH-1:WIDTH-3].
  - carry<=add3bit Cout; cnt<=cnt+1.
- On the last RUN edge (cnt==NDIG-1):
  - sum<=completed result register, with the final digit included.
  - cout<=final Cout.
  - State -> DONE.
- Latency: done is high exactly NDIG rising edges after the accepting edge (4 for WIDTH=12); throughput is one add per NDIG+1 cycles.
- start while in RUN is ignored, with no queuing; a, b and cin are don't-care outside accepting edges.
- Arithmetic: unsigned modulo 2^WIDTH; cout is the true carry out of bit WIDTH-1.
- No overflow flag.
- The counter never wraps past NDIG-1 within an operation.
- Counter width is $clog2(NDIG), minimum 1.

Decomposition:
- Shared package add3bit_pkg holds the state enum (IDLE, RUN, DONE as 2-bit encoding) and the DIGIT_W=3 constant.
- Sub-module: the existing add3bit, instantiated once with ports A, B, Cin, Sum, Cout.
- The controller FSM, counter and shift registers stay in this module; no further sub-modules.

Test Plan:
- WIDTH=12: a=0xFFF, b=0x001, cin=0, start one cycle -> busy for 4 cycles, then done for 1 cycle with sum=0x000, cout=1.
- a=0x123, b=0x456, cin=1 -> done 4 edges after accept; sum=0x57A, cout=0; sum holds 0x57A for 10 idle cycles.
- Exhaustive sweep of a, b over 0..0x3F (upper bits 0) and cin=0/1 -> every result matches the {cout,sum} model.
- Start pulsed with new operands during the 2nd RUN cycle -> ignored; the original result is returned and only one done pulse occurs.
- Start held high continuously (0x7FF+0x001, then 0xABC+0x544) -> the second add is accepted in the DONE cycle; results are 0x800/cout=0 and 0x000/cout=1, with done pulses 5 cycles apart.
- rst asserted asynchronously, mid-clock, in the 3rd RUN cycle -> busy=0, done=0, sum=0 and cout=0 immediately; no done follows; the next start completes normally.
